pipeline_scoreboard: RTL and testbench

PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

---
 rtl/pipeline_scoreboard_pkg.sv | 21 ++
 rtl/pipeline_scoreboard_sb_entry.sv | 54 +++++
 rtl/pipeline_scoreboard.sv | 120 ++++++++++++
 tb/tb_pipeline_scoreboard.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_scoreboard_pkg.sv
// Shared constants for the register scoreboard: register count, latency range,
// derived widths and the latency classes used by the decode stage.
package pipeline_scoreboard_pkg;

  localparam int unsigned NREG    = 32;
  localparam int unsigned MAX_LAT = 7;
  localparam int unsigned CNTW    = 32;
  localparam int unsigned RW      = $clog2(NREG);
  localparam int unsigned LW      = $clog2(MAX_LAT + 1);

  // Latency classes: cycles after issue before the result can be forwarded.
  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;
  localparam int unsigned LAT_MUL  = 3;

  // Latencies beyond the tracked range saturate at the largest tracked value.
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/pipeline_scoreboard_sb_entry.sv
// One scoreboard slot: a pending-write flag plus a countdown of cycles until
// the pending result becomes forwardable.
module sb_entry
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned MaxLat = MAX_LAT,
  parameter int unsigned LatW   = LW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            set_i,
  input  logic [LatW-1:0] lat_i,
  input  logic            clr_i,
  output logic            pend_o,
  output logic            pend_d_o,
  output logic [LatW-1:0] cnt_o
);

  logic            pend_q, pend_d;
  logic [LatW-1:0] cnt_q, cnt_d;

  // Next state: clear of a live entry beats a new claim, which beats the countdown.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - LatW'(1);
    end
    // Clearing an idle slot is a no-op, so a same-cycle claim still lands.
    if (clr_i && pend_q) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end else if (set_i) begin
      pend_d = 1'b1;
      cnt_d  = LatW'(clamp_lat(32'(lat_i), MaxLat));
    end
  end

  // Slot state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o   = pend_q;
  assign pend_d_o = pend_d;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/pipeline_scoreboard.sv
// Register scoreboard for the in-order pipeline: tracks pending writes per
// register and stalls decode on RAW (result not yet forwardable) and WAW hazards.
module pipeline_scoreboard #(
  parameter int unsigned NREG    = pipeline_scoreboard_pkg::NREG,
  parameter int unsigned MAX_LAT = pipeline_scoreboard_pkg::MAX_LAT,
  parameter int unsigned CNTW    = pipeline_scoreboard_pkg::CNTW,
  localparam int unsigned RW     = $clog2(NREG),
  localparam int unsigned LW     = $clog2(MAX_LAT + 1),
  localparam int unsigned OW     = RW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_reg_write,
  input  logic [LW-1:0]   id_lat,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  output logic            stall,
  output logic            issue,
  output logic [NREG-1:0] busy_vec,
  output logic [OW-1:0]   outstanding,
  output logic [CNTW-1:0] stall_cycles
);

  logic [NREG-1:0] pend, pend_next;
  logic [LW-1:0]   cnt [NREG];
  logic [NREG-1:0] set_vec, clr_vec;
  logic            raw1, raw2, waw;
  logic            last_v_q, last_v_d;
  logic [RW-1:0]   last_rd_q, last_rd_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [CNTW-1:0] stall_cycles_q, stall_cycles_d;
  logic            unused_slot0;

  // Register 0 is hard-wired idle; its set/clear strobes are dropped.
  assign pend[0]      = 1'b0;
  assign pend_next[0] = 1'b0;
  assign cnt[0]       = '0;
  assign unused_slot0 = set_vec[0] ^ clr_vec[0];

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(
      .MaxLat (MAX_LAT),
      .LatW   (LW)
    ) u_entry (
      .clk_i    (clk),
      .rst_i    (rst),
      .set_i    (set_vec[r]),
      .lat_i    (id_lat),
      .clr_i    (clr_vec[r]),
      .pend_o   (pend[r]),
      .pend_d_o (pend_next[r]),
      .cnt_o    (cnt[r])
    );
  end

  // Hazards come from current state only, so stall has no register delay.
  assign raw1  = id_rs1_used && pend[id_rs1] && (cnt[id_rs1] != '0);
  assign raw2  = id_rs2_used && pend[id_rs2] && (cnt[id_rs2] != '0);
  assign waw   = id_reg_write && (id_rd != '0) && pend[id_rd];
  assign stall = !rst && id_valid && !flush && (raw1 || raw2 || waw);
  assign issue = !rst && id_valid && !stall && !flush;

  // Per-slot claim and release strobes: issue claims rd, write-back and a
  // flush of the previous cycle's issue release.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue && id_reg_write) begin
      set_vec[id_rd] = 1'b1;
    end
    if (wb_valid) begin
      clr_vec[wb_rd] = 1'b1;
    end
    if (flush && last_v_q) begin
      clr_vec[last_rd_q] = 1'b1;
    end
  end

  // Next-state for flush tracking, occupancy popcount and the stall counter.
  always_comb begin
    last_v_d  = issue && id_reg_write && (id_rd != '0);
    last_rd_d = id_rd;
    // Popcount of the next pending set, so the register matches busy_vec.
    outstanding_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      outstanding_d = outstanding_d + OW'(pend_next[i]);
    end
    stall_cycles_d = stall_cycles_q;
    if (stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNTW'(1);
    end
  end

  // Bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_v_q       <= 1'b0;
      last_rd_q      <= '0;
      outstanding_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      last_v_q       <= last_v_d;
      last_rd_q      <= last_rd_d;
      outstanding_q  <= outstanding_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign busy_vec     = rst ? '0 : pend;
  assign outstanding  = rst ? '0 : outstanding_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed hazard scenarios plus
// randomized traffic against a timestamp-based reference model.
module tb_pipeline_scoreboard;
  import pipeline_scoreboard_pkg::*;

  localparam int unsigned OW      = RW + 1;
  localparam int unsigned D2_NREG = 8;
  localparam int unsigned D2_MAX  = 5;
  localparam int unsigned D2_CNTW = 4;
  localparam int unsigned D2_RW   = 3;
  localparam int unsigned D2_LW   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic            rst, id_valid, id_rs1_used, id_rs2_used, id_reg_write, flush, wb_valid;
  logic [RW-1:0]   id_rs1, id_rs2, id_rd, wb_rd;
  logic [LW-1:0]   id_lat;
  logic            stall, issue;
  logic [NREG-1:0] busy_vec;
  logic [OW-1:0]   outstanding;
  logic [CNTW-1:0] stall_cycles;

  // Small-configuration DUT for clamping and counter saturation
  logic               d2_rst, d2_id_valid, d2_rs1_used, d2_reg_write;
  logic [D2_RW-1:0]   d2_rs1, d2_rd;
  logic [D2_LW-1:0]   d2_lat;
  logic               d2_stall, d2_issue;
  logic [D2_NREG-1:0] d2_busy;
  logic [D2_RW:0]     d2_outstanding;
  logic [D2_CNTW-1:0] d2_stall_cycles;

  pipeline_scoreboard #(.NREG(NREG), .MAX_LAT(MAX_LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_lat(id_lat), .flush(flush), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .stall(stall), .issue(issue), .busy_vec(busy_vec),
    .outstanding(outstanding), .stall_cycles(stall_cycles)
  );

  pipeline_scoreboard #(.NREG(D2_NREG), .MAX_LAT(D2_MAX), .CNTW(D2_CNTW)) dut2 (
    .clk(clk), .rst(d2_rst), .id_valid(d2_id_valid), .id_rs1(d2_rs1), .id_rs2(3'd0),
    .id_rs1_used(d2_rs1_used), .id_rs2_used(1'b0), .id_rd(d2_rd),
    .id_reg_write(d2_reg_write), .id_lat(d2_lat), .flush(1'b0), .wb_valid(1'b0),
    .wb_rd(3'd0), .stall(d2_stall), .issue(d2_issue), .busy_vec(d2_busy),
    .outstanding(d2_outstanding), .stall_cycles(d2_stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a register is pending until released, and its result is
  // forwardable from an absolute cycle number recorded at issue.
  bit     m_pend  [NREG];
  longint m_ready [NREG];
  bit     m_last_v;
  int     m_last_rd;
  longint m_stalls;
  longint cyc = 0;

  function automatic bit m_stall();
    bit raw1 = id_rs1_used && m_pend[id_rs1] && (cyc < m_ready[id_rs1]);
    bit raw2 = id_rs2_used && m_pend[id_rs2] && (cyc < m_ready[id_rs2]);
    bit waw  = id_reg_write && (id_rd != 0) && m_pend[id_rd];
    if (rst) return 1'b0;
    return id_valid && !flush && (raw1 || raw2 || waw);
  endfunction

  function automatic bit m_issue();
    return !rst && id_valid && !flush && !m_stall();
  endfunction

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] v = '0;
    for (int r = 0; r < NREG; r++) v[r] = m_pend[r];
    return v;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  // Advance model and DUT by one clock; returns just after the falling edge.
  task automatic step();
    bit s   = m_stall();
    bit iss = m_issue();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_pend[r]  = 1'b0;
        m_ready[r] = 0;
      end
      m_last_v = 1'b0;
      m_stalls = 0;
    end else begin
      if (wb_valid && wb_rd != 0) m_pend[wb_rd] = 1'b0;
      if (flush && m_last_v) m_pend[m_last_rd] = 1'b0;
      if (iss && id_reg_write && id_rd != 0) begin
        m_pend[id_rd]  = 1'b1;
        m_ready[id_rd] = cyc + 1 + ((id_lat > MAX_LAT) ? MAX_LAT : id_lat);
      end
      m_last_v  = iss && id_reg_write && (id_rd != 0);
      m_last_rd = int'(id_rd);
      if (s && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = '0; id_reg_write = 0; id_lat = '0; flush = 0; wb_valid = 0; wb_rd = '0;
  endtask

  task automatic set_instr(input int rs1, input int u1, input int rs2, input int u2,
                           input int rd, input int we, input int lat);
    id_valid = 1; id_rs1 = RW'(rs1); id_rs1_used = u1[0]; id_rs2 = RW'(rs2);
    id_rs2_used = u2[0]; id_rd = RW'(rd); id_reg_write = we[0]; id_lat = LW'(lat);
  endtask

  task automatic release_reg(input int r);
    idle(); wb_valid = 1; wb_rd = RW'(r); step(); idle();
  endtask

  task automatic test_reset();
    rst = 1; idle(); step(); step();
    set_instr(5, 1, 6, 1, 5, 1, 0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %0b want 0", issue); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy: got %0h want 0", busy_vec); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
    step(); rst = 0; idle();
  endtask

  task automatic test_alu_forward();
    idle(); set_instr(0, 0, 0, 0, 5, 1, LAT_ALU); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL alu_issue: got %0b want 1", issue); end
    step();
    idle(); set_instr(5, 1, 0, 0, 0, 0, LAT_ALU); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_dep_stall: got %0b want 0", stall); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL alu_dep_issue: got %0b want 1", issue); end
    checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL alu_busy5: got %0b want 1", busy_vec[5]); end
    step();
    release_reg(5); #1;
    checks++; if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL alu_wb_clear: got %0b want 0", busy_vec[5]); end
  endtask

  task automatic test_load_use();
    idle(); set_instr(0, 0, 0, 0, 6, 1, LAT_LOAD); step();
    idle(); set_instr(0, 0, 6, 1, 11, 1, LAT_ALU); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %0b want 1", stall); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL load_use_hold: got %0b want 0", issue); end
    step(); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %0b want 0", stall); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL load_use_issue: got %0b want 1", issue); end
    step(); #1;
    checks++; if (stall_cycles !== CNTW'(m_stalls)) begin errors++; $display("FAIL load_use_count: got %0d want %0d", stall_cycles, m_stalls); end
    release_reg(6); release_reg(11);
  endtask

  task automatic test_mul_waw();
    int n;
    idle(); set_instr(0, 0, 0, 0, 7, 1, LAT_MUL); step();
    idle(); set_instr(7, 1, 0, 0, 0, 0, LAT_ALU);
    n = 0;
    while (n < 12) begin #1; if (stall !== 1'b1) break; n++; step(); end
    checks++; if (n != LAT_MUL) begin errors++; $display("FAIL mul_stall_len: got %0d want %0d", n, LAT_MUL); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL mul_dep_issue: got %0b want 1", issue); end
    step();
    idle(); set_instr(0, 0, 0, 0, 7, 1, LAT_ALU);
    n = 0;
    for (int k = 0; k < 5; k++) begin #1; if (stall === 1'b1) n++; step(); end
    checks++; if (n != 5) begin errors++; $display("FAIL waw_hold: got %0d want 5", n); end
    wb_valid = 1; wb_rd = RW'(7); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_wb_cycle: got %0b want 1", stall); end
    step(); wb_valid = 0; #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL waw_after_wb: got stall=%0b issue=%0b want 0/1", stall, issue); end
    step(); #1;
    checks++; if (busy_vec[7] !== 1'b1) begin errors++; $display("FAIL waw_new_owner: got %0b want 1", busy_vec[7]); end
    release_reg(7);
  endtask

  task automatic test_flush();
    idle(); set_instr(0, 0, 0, 0, 8, 1, 2); step();
    idle(); set_instr(0, 0, 0, 0, 9, 1, LAT_ALU); flush = 1; #1;
    checks++; if (issue !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_block: got issue=%0b stall=%0b want 0/0", issue, stall); end
    checks++; if (outstanding !== OW'(1)) begin errors++; $display("FAIL flush_before: got %0d want 1", outstanding); end
    step(); idle(); #1;
    checks++; if (busy_vec[8] !== 1'b0 || busy_vec[9] !== 1'b0) begin errors++; $display("FAIL flush_clear: got b8=%0b b9=%0b want 0/0", busy_vec[8], busy_vec[9]); end
    checks++; if (outstanding !== OW'(0)) begin errors++; $display("FAIL flush_after: got %0d want 0", outstanding); end
    set_instr(0, 0, 0, 0, 10, 1, LAT_ALU); step();
    idle(); flush = 1; wb_valid = 1; wb_rd = RW'(10); step(); idle(); #1;
    checks++; if (busy_vec[10] !== 1'b0) begin errors++; $display("FAIL flush_wb_same: got %0b want 0", busy_vec[10]); end
  endtask

  task automatic test_edge_cases();
    int n;
    idle(); set_instr(0, 0, 0, 0, 0, 1, LAT_LOAD); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL r0_issue: got %0b want 1", issue); end
    step(); idle(); set_instr(0, 1, 0, 1, 0, 1, LAT_ALU); #1;
    checks++; if (busy_vec[0] !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL r0_idle: got b0=%0b stall=%0b want 0/0", busy_vec[0], stall); end
    step();
    release_reg(12); #1;
    checks++; if (busy_vec !== '0 || outstanding !== OW'(0)) begin errors++; $display("FAIL idle_wb: got %0h/%0d want 0/0", busy_vec, outstanding); end
    // 15 does not fit the 3-bit latency port; it arrives as the all-ones maximum.
    set_instr(0, 0, 0, 0, 13, 1, 15); step();
    idle(); set_instr(13, 1, 0, 0, 0, 0, LAT_ALU);
    n = 0;
    while (n < 12) begin #1; if (stall !== 1'b1) break; n++; step(); end
    checks++; if (n != MAX_LAT) begin errors++; $display("FAIL lat_max_len: got %0d want %0d", n, MAX_LAT); end
    step(); release_reg(13);
  endtask

  task automatic test_reset_mid_stall();
    for (int r = 1; r <= 4; r++) begin idle(); set_instr(0, 0, 0, 0, r, 1, MAX_LAT); step(); end
    idle(); set_instr(4, 1, 0, 0, 20, 1, LAT_ALU); #1;
    checks++; if (stall !== 1'b1 || outstanding !== OW'(4)) begin errors++; $display("FAIL pre_rst: got stall=%0b out=%0d want 1/4", stall, outstanding); end
    step(); rst = 1; #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b0 || busy_vec !== '0) begin errors++; $display("FAIL in_rst: got stall=%0b issue=%0b busy=%0h want 0/0/0", stall, issue, busy_vec); end
    step(); rst = 0; #1;
    checks++; if (busy_vec !== '0 || outstanding !== OW'(0)) begin errors++; $display("FAIL post_rst_busy: got %0h/%0d want 0/0", busy_vec, outstanding); end
    checks++; if (stall_cycles !== '0 || stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got cnt=%0d stall=%0b want 0/0", stall_cycles, stall); end
    step(); release_reg(20);
  endtask

  task automatic test_random();
    logic [NREG-1:0] exp_busy;
    logic [OW-1:0]   exp_out;
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = RW'($urandom_range(0, 7));
      id_rs2       = RW'($urandom_range(0, 7));
      id_rs1_used  = ($urandom_range(0, 1) == 1);
      id_rs2_used  = ($urandom_range(0, 1) == 1);
      id_rd        = RW'($urandom_range(0, 7));
      id_reg_write = ($urandom_range(0, 1) == 1);
      id_lat       = LW'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 9) == 0);
      wb_valid     = ($urandom_range(0, 3) == 0);
      wb_rd        = RW'($urandom_range(0, 7));
      #1;
      exp_busy = rst ? '0 : m_busy();
      exp_out  = rst ? '0 : OW'(m_count());
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", i, stall, m_stall()); end
      checks++; if (issue !== m_issue()) begin errors++; $display("FAIL rnd_issue[%0d]: got %0b want %0b", i, issue, m_issue()); end
      checks++; if (busy_vec !== exp_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %0h want %0h", i, busy_vec, exp_busy); end
      checks++; if (outstanding !== exp_out) begin errors++; $display("FAIL rnd_outstanding[%0d]: got %0d want %0d", i, outstanding, exp_out); end
      checks++; if (stall_cycles !== CNTW'(m_stalls)) begin errors++; $display("FAIL rnd_stall_cycles[%0d]: got %0d want %0d", i, stall_cycles, m_stalls); end
      step();
    end
    rst = 0; idle();
  endtask

  task automatic test_clamp_saturate();
    int n;
    d2_rst = 1; @(posedge clk); @(negedge clk); d2_rst = 0;
    d2_id_valid = 1; d2_rd = 3'd3; d2_reg_write = 1; d2_lat = 3'd7;
    @(posedge clk); @(negedge clk);
    d2_reg_write = 0; d2_rd = 3'd0; d2_rs1 = 3'd3; d2_rs1_used = 1;
    n = 0;
    while (n < 12) begin #1; if (d2_stall !== 1'b1) break; n++; @(posedge clk); @(negedge clk); end
    checks++; if (n != D2_MAX) begin errors++; $display("FAIL clamp_len: got %0d want %0d", n, D2_MAX); end
    checks++; if (d2_stall_cycles !== 4'd5) begin errors++; $display("FAIL clamp_count: got %0d want 5", d2_stall_cycles); end
    checks++; if (d2_outstanding !== 4'd1 || d2_busy !== 8'h08) begin errors++; $display("FAIL clamp_busy: got %0d/%0h want 1/08", d2_outstanding, d2_busy); end
    d2_rs1_used = 0; d2_rd = 3'd3; d2_reg_write = 1;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (d2_stall !== 1'b1) begin errors++; $display("FAIL sat_waw: got %0b want 1", d2_stall); end
    checks++; if (d2_stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d want 15", d2_stall_cycles); end
    d2_id_valid = 0; d2_reg_write = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; idle();
    d2_rst = 1; d2_id_valid = 0; d2_rs1_used = 0; d2_reg_write = 0;
    d2_rs1 = '0; d2_rd = '0; d2_lat = '0;
    for (int r = 0; r < NREG; r++) begin m_pend[r] = 0; m_ready[r] = 0; end
    m_last_v = 0; m_last_rd = 0; m_stalls = 0;
    @(negedge clk);
    test_reset();
    test_alu_forward();
    test_load_use();
    test_mul_waw();
    test_flush();
    test_edge_cases();
    test_reset_mid_stall();
    test_random();
    test_clamp_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
